// File: rtl/noc_pkg.sv
// noc_pkg: flit type, idle token, header field helpers and FSM state encodings for the ring stop
package noc_pkg;
   localparam int MAX_DW = 32;
   typedef struct packed {
      logic              ctl;
      logic [MAX_DW-1:0] data;
   } flit_t;
   localparam flit_t IDLE_FLIT = '{ctl: 1'b1, data: '0};
   typedef enum logic [1:0] {IN_IDLE, IN_FWD, IN_RX} in_state_e;
   typedef enum logic [1:0] {OUT_IDLE, OUT_FWD, OUT_INJ} out_state_e;
   function automatic logic [MAX_DW-1:0] hdr_field(input logic [MAX_DW-1:0] d, input int lsb, input int w);
      return (d >> lsb) & ((MAX_DW'(1) << w) - MAX_DW'(1));
   endfunction
   function automatic logic [MAX_DW-1:0] hdr_dest(input logic [MAX_DW-1:0] d, input int id_w);
      return hdr_field(d, 0, id_w);
   endfunction
   function automatic logic [MAX_DW-1:0] hdr_len(input logic [MAX_DW-1:0] d, input int id_w, input int len_w);
      return hdr_field(d, id_w, len_w);
   endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: show-ahead synchronous FIFO with full/empty/count, any depth
module noc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic wr, rd;
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign dout  = mem[rp];
   always_ff @(posedge clk) begin
      if (!reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
         if (rd) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
         count <= count + CW'(wr) - CW'(rd);
      end
   end
   always_ff @(posedge clk) if (wr) mem[wp] <= din;
endmodule

// File: rtl/noc_ring_node.sv
// noc_ring_node: ring stop that forwards through-traffic, ejects local packets and injects TX packets into gaps
module noc_ring_node
   import noc_pkg::*;
#(
   parameter int DW        = 8,
   parameter int ID_W      = 2,
   parameter int LEN_W     = 3,
   parameter int NODE_ID   = 0,
   parameter int RX_DEPTH  = 8,
   parameter int TX_DEPTH  = 16,
   parameter int BYP_DEPTH = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          noc_to_dev_ctl,
   input  logic [DW-1:0] noc_to_dev_data,
   output logic          noc_from_dev_ctl,
   output logic [DW-1:0] noc_from_dev_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   input  logic [DW-1:0] tx_data,
   input  logic          tx_hdr,
   input  logic          tx_last,
   output logic          rx_valid,
   input  logic          rx_ready,
   output logic [DW-1:0] rx_data,
   output logic          rx_last,
   output logic          rx_overflow,
   output logic          proto_err
);
   localparam int TCW = $clog2(TX_DEPTH + 1);
   if (BYP_DEPTH < 2 ** LEN_W + 1) begin : g_byp_chk
      $error("BYP_DEPTH must be at least 2**LEN_W+1");
   end
   if (ID_W + LEN_W > DW || DW > MAX_DW) begin : g_fmt_chk
      $error("header fields must fit in DW and DW must not exceed MAX_DW");
   end
   flit_t in_q, out_q, out_nxt;
   in_state_e in_st;
   out_state_e out_st, out_st_nxt;
   logic [LEN_W-1:0] rem, in_len, out_rem, out_rem_nxt, byp_len;
   logic [TCW-1:0] tx_pkt_cnt;
   logic in_hdr, in_pay, in_self, byp_push, rx_push, fwd, inj, tx_done, tx_push;
   logic byp_full, byp_empty, rx_full, rx_empty, tx_full, tx_empty, unused;
   logic [DW:0] byp_dout, rx_dout;
   logic [DW+1:0] tx_dout;
   logic [$clog2(BYP_DEPTH+1)-1:0] byp_count;
   logic [$clog2(RX_DEPTH+1)-1:0] rx_count;
   logic [TCW-1:0] tx_count;
   assign in_len   = LEN_W'(hdr_len(in_q.data, ID_W, LEN_W));
   assign in_hdr   = in_q.ctl && in_len != '0;
   assign in_pay   = !in_q.ctl;
   assign in_self  = hdr_dest(in_q.data, ID_W) == MAX_DW'(NODE_ID);
   assign byp_push = (in_hdr && !in_self) || (in_pay && in_st == IN_FWD);
   assign rx_push  = in_pay && in_st == IN_RX;
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_q        <= IDLE_FLIT;
         in_st       <= IN_IDLE;
         rem         <= '0;
         rx_overflow <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         in_q <= flit_t'{ctl: noc_to_dev_ctl, data: MAX_DW'(noc_to_dev_data)};
         if (in_hdr) begin
            if (rem != '0) proto_err <= 1'b1;
            rem   <= in_len;
            in_st <= in_self ? IN_RX : IN_FWD;
         end else if (in_pay) begin
            if (in_st == IN_IDLE) proto_err <= 1'b1;
            else begin
               rem <= rem - 1'b1;
               if (rem == LEN_W'(1)) in_st <= IN_IDLE;
            end
            if (rx_push && rx_full) rx_overflow <= 1'b1;
         end
      end
   end
   noc_sync_fifo #(.WIDTH(DW + 1), .DEPTH(BYP_DEPTH)) u_byp (
      .clk(clk), .reset(reset), .push(byp_push), .din({in_q.ctl, in_q.data[DW-1:0]}),
      .pop(fwd), .dout(byp_dout), .full(byp_full), .empty(byp_empty), .count(byp_count));
   noc_sync_fifo #(.WIDTH(DW + 1), .DEPTH(RX_DEPTH)) u_rx (
      .clk(clk), .reset(reset), .push(rx_push), .din({rem == LEN_W'(1), in_q.data[DW-1:0]}),
      .pop(rx_valid && rx_ready), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count));
   noc_sync_fifo #(.WIDTH(DW + 2), .DEPTH(TX_DEPTH)) u_tx (
      .clk(clk), .reset(reset), .push(tx_valid), .din({tx_hdr, tx_last, tx_data}),
      .pop(inj), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count));
   assign tx_ready = !tx_full;
   assign tx_push  = tx_valid && !tx_full;
   assign rx_valid = !rx_empty;
   assign rx_data  = rx_dout[DW-1:0];
   assign rx_last  = !rx_empty && rx_dout[DW];
   assign unused   = ^{byp_full, byp_count, rx_count, tx_count, out_q.data};
   assign byp_len  = LEN_W'(hdr_len(MAX_DW'(byp_dout[DW-1:0]), ID_W, LEN_W));
   // bypass always wins; injection only starts from idle with an empty bypass and runs to its tail
   assign fwd      = !byp_empty && out_st != OUT_INJ;
   assign inj      = out_st == OUT_INJ ? !tx_empty : out_st == OUT_IDLE && byp_empty && tx_pkt_cnt != '0;
   assign tx_done  = inj && tx_dout[DW];
   always_comb begin
      out_nxt     = fwd ? flit_t'{ctl: byp_dout[DW], data: MAX_DW'(byp_dout[DW-1:0])}
                  : inj ? flit_t'{ctl: tx_dout[DW+1], data: MAX_DW'(tx_dout[DW-1:0])} : IDLE_FLIT;
      out_st_nxt  = out_st;
      out_rem_nxt = out_rem;
      if (fwd) begin
         out_rem_nxt = byp_dout[DW] ? byp_len : (out_rem != '0 ? out_rem - 1'b1 : '0);
         out_st_nxt  = out_rem_nxt != '0 ? OUT_FWD : OUT_IDLE;
      end else if (inj) out_st_nxt = tx_dout[DW] ? OUT_IDLE : OUT_INJ;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q      <= IDLE_FLIT;
         out_st     <= OUT_IDLE;
         out_rem    <= '0;
         tx_pkt_cnt <= '0;
      end else begin
         out_q      <= out_nxt;
         out_st     <= out_st_nxt;
         out_rem    <= out_rem_nxt;
         tx_pkt_cnt <= tx_pkt_cnt + TCW'(tx_push && tx_last) - TCW'(tx_done);
      end
   end
   assign noc_from_dev_ctl  = out_q.ctl;
   assign noc_from_dev_data = out_q.data[DW-1:0];
endmodule

// File: tb/tb_noc_ring_node.sv
// tb_noc_ring_node: directed table-driven and sequence checks for the ring stop at NODE_ID=1
module tb_noc_ring_node;
   logic clk = 1'b0, reset = 1'b0;
   logic noc_to_dev_ctl = 1'b1, noc_from_dev_ctl;
   logic [7:0] noc_to_dev_data = 8'h00, noc_from_dev_data;
   logic tx_valid = 1'b0, tx_ready, tx_hdr = 1'b0, tx_last = 1'b0;
   logic [7:0] tx_data = 8'h00, rx_data;
   logic rx_valid, rx_ready = 1'b1, rx_last, rx_overflow, proto_err;
   int checks = 0, errors = 0;
   logic cap_en = 1'b0;
   logic [8:0] cap_q[$];

   typedef struct packed {
      logic ctl; logic [7:0] d; logic ectl; logic [7:0] ed; logic erv; logic [7:0] erd; logic erl;
   } vec_t;
   vec_t tbl[13];

   noc_ring_node #(.NODE_ID(1)) dut (
      .clk(clk), .reset(reset),
      .noc_to_dev_ctl(noc_to_dev_ctl), .noc_to_dev_data(noc_to_dev_data),
      .noc_from_dev_ctl(noc_from_dev_ctl), .noc_from_dev_data(noc_from_dev_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_hdr(tx_hdr), .tx_last(tx_last),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
      .rx_overflow(rx_overflow), .proto_err(proto_err));

   always #5 clk = ~clk;
   always @(negedge clk) if (cap_en) cap_q.push_back({noc_from_dev_ctl, noc_from_dev_data});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ring(input logic c, input logic [7:0] d);
      noc_to_dev_ctl  = c;
      noc_to_dev_data = d;
      tick();
   endtask

   task automatic load_tx;
      logic [7:0] pkt [5] = '{8'h13, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      for (int k = 0; k < 5; k++) begin
         tx_valid = 1'b1; tx_data = pkt[k]; tx_hdr = (k == 0); tx_last = (k == 4);
         tick();
      end
      tx_valid = 1'b0; tx_hdr = 1'b0; tx_last = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [8:0] exp_inj [8] = '{9'h113, 9'h0B1, 9'h0B2, 9'h0B3, 9'h0B4, 9'h108, 9'h0C1, 9'h0C2};
      logic [8:0] rx_got[$];
      int s;
      logic found;
      tbl[0]  = '{1'b1, 8'h0E, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 8'hA1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 8'hA2, 1'b1, 8'h0E, 1'b0, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 8'hA3, 1'b0, 8'hA1, 1'b0, 8'h00, 1'b0};
      tbl[4]  = '{1'b1, 8'h00, 1'b0, 8'hA2, 1'b0, 8'h00, 1'b0};
      tbl[5]  = '{1'b1, 8'h00, 1'b0, 8'hA3, 1'b0, 8'h00, 1'b0};
      tbl[6]  = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[7]  = '{1'b1, 8'h09, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[8]  = '{1'b0, 8'h55, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 8'hAA, 1'b1, 8'h00, 1'b1, 8'h55, 1'b0};
      tbl[10] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 8'hAA, 1'b1};
      tbl[11] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[12] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", noc_from_dev_ctl, 1);
      chk("rst_data", noc_from_dev_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_last", rx_last, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_overflow", rx_overflow, 0);
      chk("rst_proto_err", proto_err, 0);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         ring(tbl[i].ctl, tbl[i].d);
         chk($sformatf("vec%0d_ctl", i), noc_from_dev_ctl, tbl[i].ectl);
         chk($sformatf("vec%0d_data", i), noc_from_dev_data, tbl[i].ed);
         chk($sformatf("vec%0d_rx_valid", i), rx_valid, tbl[i].erv);
         if (tbl[i].erv) begin
            chk($sformatf("vec%0d_rx_data", i), rx_data, tbl[i].erd);
            chk($sformatf("vec%0d_rx_last", i), rx_last, tbl[i].erl);
         end
      end

      cap_q.delete();
      cap_en = 1'b1;
      load_tx();
      tick();
      ring(1'b1, 8'h08);
      ring(1'b0, 8'hC1);
      ring(1'b0, 8'hC2);
      noc_to_dev_ctl = 1'b1; noc_to_dev_data = 8'h00;
      repeat (15) tick();
      cap_en = 1'b0;
      s = -1;
      foreach (cap_q[j]) if (s < 0 && cap_q[j] != 9'h100) s = j;
      chk("inj_start_seen", s >= 0, 1);
      if (s < 0) s = 0;
      for (int j = 0; j < 9; j++)
         chk($sformatf("inj_flit%0d", j), (s + j < cap_q.size()) ? cap_q[s + j] : 9'h1FF,
             (j < 8) ? exp_inj[j] : 9'h100);
      chk("tx_pkt_cnt_after_inj", dut.tx_pkt_cnt, 0);
      chk("inj_rx_valid", rx_valid, 0);

      rx_ready = 1'b0;
      ring(1'b1, 8'h15);
      for (int k = 1; k <= 5; k++) ring(1'b0, 8'(k));
      ring(1'b1, 8'h15);
      for (int k = 6; k <= 10; k++) ring(1'b0, 8'(k));
      noc_to_dev_ctl = 1'b1; noc_to_dev_data = 8'h00;
      repeat (4) tick();
      chk("ovf_set", rx_overflow, 1);
      chk("ovf_rx_valid", rx_valid, 1);
      for (int k = 0; k < 12; k++) begin
         if (rx_valid) rx_got.push_back({rx_last, rx_data});
         rx_ready = 1'b1;
         tick();
      end
      chk("ovf_drain_count", rx_got.size(), 8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("ovf_rx%0d", k), (k < rx_got.size()) ? rx_got[k] : 9'h1FF, {k == 4, 8'(k + 1)});
      chk("ovf_sticky", rx_overflow, 1);
      chk("ovf_proto_err", proto_err, 0);
      chk("ovf_out_idle", {noc_from_dev_ctl, noc_from_dev_data}, 9'h100);

      ring(1'b0, 8'h77);
      noc_to_dev_ctl = 1'b1; noc_to_dev_data = 8'h00;
      tick();
      chk("stray_payload_proto_err", proto_err, 1);
      chk("stray_payload_rx_valid", rx_valid, 0);
      chk("stray_payload_out_idle", {noc_from_dev_ctl, noc_from_dev_data}, 9'h100);

      load_tx();
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (noc_from_dev_ctl && noc_from_dev_data == 8'h13) found = 1'b1;
         else tick();
      end
      chk("mid_inj_header_seen", found, 1);
      reset = 1'b0;
      tick();
      chk("midrst_ctl", noc_from_dev_ctl, 1);
      chk("midrst_data", noc_from_dev_data, 0);
      chk("midrst_tx_ready", tx_ready, 1);
      chk("midrst_rx_valid", rx_valid, 0);
      chk("midrst_tx_pkt_cnt", dut.tx_pkt_cnt, 0);
      chk("midrst_rx_overflow", rx_overflow, 0);
      chk("midrst_proto_err", proto_err, 0);
      reset = 1'b1;
      repeat (6) tick();
      chk("post_rst_out_idle", {noc_from_dev_ctl, noc_from_dev_data}, 9'h100);
      chk("post_rst_rx_valid", rx_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
